sensor_pwr_seq: RTL and testbench



---
 rtl/sensor_pwr_pkg.sv | 15 +
 rtl/sensor_pwr_step_timer.sv | 43 ++++
 rtl/sensor_pwr_seq.sv | 131 +++++++++++++
 tb/tb_sensor_pwr_seq.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_pwr_pkg.sv
// Shared stage encoding for the sensor power sequencer.
package sensor_pwr_pkg;

  localparam int unsigned STAGE_W = 3;

  typedef enum logic [STAGE_W-1:0] {
    STG_OFF   = 3'd0,
    STG_IO    = 3'd1,
    STG_CORE  = 3'd2,
    STG_BOOST = 3'd3,
    STG_BIAS  = 3'd4,
    STG_ON    = 3'd5
  } stage_t;

endpackage

// File: rtl/sensor_pwr_step_timer.sv
// Loadable dwell down-counter that saturates at zero; reports zero now and zero after this edge.
module sensor_pwr_step_timer #(
  parameter int unsigned STEP_CYC = 100000,
  parameter int unsigned TMR_W    = $clog2(STEP_CYC)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clear,
  output logic zero,
  output logic zero_nxt_c
);

  localparam logic [TMR_W-1:0] LOAD_VAL = TMR_W'(STEP_CYC - 1);

  logic [TMR_W-1:0] cnt;
  logic [TMR_W-1:0] cnt_d;

  // clear wins over load so a fault always leaves the timer idle
  always_comb begin
    cnt_d = cnt;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = LOAD_VAL;
    end else if (cnt != '0) begin
      cnt_d = cnt - TMR_W'(1);
    end
  end

  assign zero_nxt_c = (cnt_d == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      zero <= 1'b1;
    end else begin
      cnt  <= cnt_d;
      zero <= zero_nxt_c;
    end
  end

endmodule

// File: rtl/sensor_pwr_seq.sv
// Ordered, timed power ramp for the thermal sensor rails and enable pin.
// Optional rail-supervisor fault handling is built when SENSOR_PWR_FAULT_EN is defined.
module sensor_pwr_seq
  import sensor_pwr_pkg::*;
#(
  parameter int unsigned STEP_CYC = 100000,
  parameter int unsigned TMR_W    = $clog2(STEP_CYC)
) (
  input  logic clk,
  input  logic rst,
  input  logic pwr_on,
  input  logic pwr_fault,
  output logic io_pwr_ena_n,
  output logic core_pwr_ena,
  output logic bias_boost_pwr_ena,
  output logic bias_pwr_ena,
  output logic sensor_ena,
  output logic ready,
  output logic busy,
  output logic fault_flag
);

  stage_t stage_q;
  stage_t stage_d;
  stage_t tgt;
  stage_t tgt_d;
  logic   fault_s;
  logic   flag_q;
  logic   flag_d;
  logic   tmr_load;
  logic   tmr_clear;
  logic   tmr_zero;
  logic   tmr_zero_nxt;

`ifdef SENSOR_PWR_FAULT_EN
  logic [1:0] fault_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_sync <= 2'b00;
    end else begin
      fault_sync <= {fault_sync[0], pwr_fault};
    end
  end

  assign fault_s = fault_sync[1];

  // flag latches on a synced fault and waits for software to drop the request
  always_comb begin
    flag_d = flag_q;
    if (fault_s) begin
      flag_d = 1'b1;
    end else if (!pwr_on) begin
      flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q <= 1'b0;
    end else begin
      flag_q <= flag_d;
    end
  end
`else
  logic unused_fault;

  assign unused_fault = pwr_fault;
  assign fault_s      = 1'b0;
  assign flag_d       = 1'b0;
  assign flag_q       = 1'b0;
`endif

  assign fault_flag = flag_q;

  // one stage per completed dwell; a fault bypasses the ramp entirely
  always_comb begin
    tgt       = (pwr_on && !flag_q) ? STG_ON : STG_OFF;
    tgt_d     = (pwr_on && !flag_d) ? STG_ON : STG_OFF;
    stage_d   = stage_q;
    tmr_load  = 1'b0;
    tmr_clear = 1'b0;
    if (fault_s) begin
      stage_d   = STG_OFF;
      tmr_clear = 1'b1;
    end else if (tmr_zero && (stage_q != tgt)) begin
      tmr_load = 1'b1;
      if (stage_q < tgt) begin
        stage_d = stage_t'(stage_q + 3'd1);
      end else begin
        stage_d = stage_t'(stage_q - 3'd1);
      end
    end
  end

  sensor_pwr_step_timer #(
    .STEP_CYC (STEP_CYC),
    .TMR_W    (TMR_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (tmr_load),
    .clear      (tmr_clear),
    .zero       (tmr_zero),
    .zero_nxt_c (tmr_zero_nxt)
  );

  // outputs decoded from the next stage so they change on the same edge as the stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q            <= STG_OFF;
      io_pwr_ena_n       <= 1'b1;
      core_pwr_ena       <= 1'b0;
      bias_boost_pwr_ena <= 1'b0;
      bias_pwr_ena       <= 1'b0;
      sensor_ena         <= 1'b0;
      ready              <= 1'b0;
      busy               <= 1'b0;
    end else begin
      stage_q            <= stage_d;
      io_pwr_ena_n       <= (stage_d == STG_OFF);
      core_pwr_ena       <= (stage_d >= STG_CORE);
      bias_boost_pwr_ena <= (stage_d >= STG_BOOST);
      bias_pwr_ena       <= (stage_d >= STG_BIAS);
      sensor_ena         <= (stage_d == STG_ON);
      ready              <= (stage_d == STG_ON) && tmr_zero_nxt && !flag_d;
      busy               <= (stage_d != tgt_d) || !tmr_zero_nxt;
    end
  end

endmodule

// File: tb/tb_sensor_pwr_seq.sv
// Self-checking bench for sensor_pwr_seq: directed ramp timing plus randomized traffic against a reference model.
module tb_sensor_pwr_seq;

  localparam int unsigned STEP = 4;

  logic clk       = 1'b0;
  logic rst       = 1'b1;
  logic pwr_on    = 1'b0;
  logic pwr_fault = 1'b0;
  logic io_pwr_ena_n, core_pwr_ena, bias_boost_pwr_ena, bias_pwr_ena;
  logic sensor_ena, ready, busy, fault_flag;

  int errors    = 0;
  int checks    = 0;
  int ecnt      = 0;
  int max_rails = 0;

  // reference model state
  int       m_stage;
  int       m_timer;
  bit       m_flag;
  bit [1:0] m_sync;
  logic [7:0] m_out;

  sensor_pwr_seq #(.STEP_CYC(STEP)) dut (
    .clk                (clk),
    .rst                (rst),
    .pwr_on             (pwr_on),
    .pwr_fault          (pwr_fault),
    .io_pwr_ena_n       (io_pwr_ena_n),
    .core_pwr_ena       (core_pwr_ena),
    .bias_boost_pwr_ena (bias_boost_pwr_ena),
    .bias_pwr_ena       (bias_pwr_ena),
    .sensor_ena         (sensor_ena),
    .ready              (ready),
    .busy               (busy),
    .fault_flag         (fault_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, ecnt);
    end
  endtask

  function automatic logic [7:0] dut_vec();
    return {io_pwr_ena_n, core_pwr_ena, bias_boost_pwr_ena, bias_pwr_ena,
            sensor_ena, ready, busy, fault_flag};
  endfunction

  function automatic logic [4:0] rail_vec();
    return {~io_pwr_ena_n, core_pwr_ena, bias_boost_pwr_ena, bias_pwr_ena, sensor_ena};
  endfunction

  function automatic int rails();
    return $countones(rail_vec());
  endfunction

  // rails must always be a prefix of IO, core, boost, bias, enable
  function automatic bit thermo_ok();
    logic [4:0] r;
    bit seen0;
    bit ok;
    r     = rail_vec();
    seen0 = 1'b0;
    ok    = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      if (!r[i]) seen0 = 1'b1;
      else if (seen0) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic m_reset();
    m_stage = 0;
    m_timer = 0;
    m_flag  = 1'b0;
    m_sync  = 2'b00;
    m_out   = 8'h80;
  endtask

  task automatic model_step();
    bit fs;
    int tgt;
    if (rst) begin
      m_reset();
    end else begin
      fs = 1'b0;
`ifdef SENSOR_PWR_FAULT_EN
      fs     = m_sync[1];
      m_sync = {m_sync[0], pwr_fault};
`endif
      tgt = (pwr_on && !m_flag) ? 5 : 0;
      if (fs) begin
        m_stage = 0;
        m_timer = 0;
      end else if (m_timer == 0 && m_stage != tgt) begin
        m_stage = m_stage + ((tgt > m_stage) ? 1 : -1);
        m_timer = STEP - 1;
      end else if (m_timer > 0) begin
        m_timer = m_timer - 1;
      end
      if (fs) m_flag = 1'b1;
      else if (!pwr_on) m_flag = 1'b0;
      tgt = (pwr_on && !m_flag) ? 5 : 0;
      m_out = {m_stage == 0, m_stage >= 2, m_stage >= 3, m_stage >= 4, m_stage == 5,
               (m_stage == 5 && m_timer == 0 && !m_flag),
               (m_stage != tgt || m_timer != 0), m_flag};
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    ecnt++;
    @(negedge clk);
    chk("outs", 32'(dut_vec()), 32'(m_out));
    chk("order", 32'(thermo_ok()), 32'd1);
    if (rails() > max_rails) max_rails = rails();
  endtask

  task automatic run_to(input int n);
    while (ecnt < n) tick();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    pwr_on    = 1'b0;
    pwr_fault = 1'b0;
    tick();
    rst  = 1'b0;
    ecnt = 0;
  endtask

  initial begin
    int b;
    m_reset();
    repeat (2) tick();
    chk("rst_outs", 32'(dut_vec()), 32'h80);
    rst  = 1'b0;
    ecnt = 0;

    // up-ramp: stage n at edge 11+(n-1)*STEP, ready at 10+5*STEP
    run_to(10);
    pwr_on = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      run_to(10 + (n - 1) * STEP);
      chk("up_pre", 32'(rails()), 32'(n - 1));
      tick();
      chk("up_at", 32'(rails()), 32'(n));
    end
    run_to(9 + 5 * STEP);
    chk("ready_pre", 32'(ready), 32'd0);
    tick();
    chk("ready_at", 32'(ready), 32'd1);
    chk("busy_idle", 32'(busy), 32'd0);

    // down-ramp from ready
    run_to(50);
    pwr_on = 1'b0;
    tick();
    chk("dn_ena", 32'(sensor_ena), 32'd0);
    chk("dn_ready", 32'(ready), 32'd0);
    for (int n = 3; n >= 0; n--) begin
      run_to(50 + (4 - n) * STEP);
      chk("dn_pre", 32'(rails()), 32'(n + 1));
      tick();
      chk("dn_at", 32'(rails()), 32'(n));
    end
    chk("dn_io", 32'(io_pwr_ena_n), 32'd1);

    // reversal at stage 2: running dwell completes, stage 3 never reached
    do_reset();
    max_rails = 0;
    run_to(10);
    pwr_on = 1'b1;
    run_to(17);
    chk("rev_17", 32'(rails()), 32'd2);
    pwr_on = 1'b0;
    run_to(18);
    chk("rev_18", 32'(rails()), 32'd2);
    tick();
    chk("rev_19", 32'(rails()), 32'd1);
    run_to(22);
    chk("rev_22", 32'(rails()), 32'd1);
    tick();
    chk("rev_23", 32'(rails()), 32'd0);
    run_to(30);
    chk("rev_max", 32'(max_rails), 32'd2);

    // asynchronous reset mid-ramp, then restart from stage 1
    do_reset();
    pwr_on = 1'b1;
    b = 0;
    while (rails() != 3 && b < 100) begin
      tick();
      b++;
    end
    chk("reach3", 32'(rails()), 32'd3);
    #2 rst = 1'b1;
    #1 chk("async_rst", 32'(dut_vec()), 32'h80);
    tick();
    rst  = 1'b0;
    ecnt = 0;
    tick();
    chk("restart", 32'(rails()), 32'd1);

`ifdef SENSOR_PWR_FAULT_EN
    // fault pulse sampled at edge 40 drops all rails at 42
    do_reset();
    pwr_on = 1'b1;
    run_to(39);
    chk("flt_ready", 32'(ready), 32'd1);
    pwr_fault = 1'b1;
    tick();
    pwr_fault = 1'b0;
    tick();
    chk("flt_41", 32'(rails()), 32'd5);
    tick();
    chk("flt_42", 32'(rails()), 32'd0);
    chk("flt_flag", 32'(fault_flag), 32'd1);
    run_to(45);
    chk("flt_hold", 32'(fault_flag), 32'd1);
    chk("flt_stay_off", 32'(rails()), 32'd0);
    pwr_on = 1'b0;
    tick();
    chk("flt_clr", 32'(fault_flag), 32'd0);
    pwr_on = 1'b1;
    tick();
    chk("flt_resume", 32'(rails()), 32'd1);
`else
    // fault input has no effect in this build
    do_reset();
    pwr_on = 1'b1;
    run_to(5 * STEP + 12);
    for (int i = 0; i < 20; i++) begin
      pwr_fault = 1'($urandom_range(0, 1));
      tick();
      chk("nf_flag", 32'(fault_flag), 32'd0);
      chk("nf_rails", 32'(rails()), 32'd5);
    end
    pwr_fault = 1'b0;
`endif

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 999) == 0);
      if ((i % 600) < 300) begin
        if ($urandom_range(0, 15) == 0) pwr_on = ~pwr_on;
      end else begin
        if ($urandom_range(0, 59) == 0) pwr_on = ~pwr_on;
      end
`ifdef SENSOR_PWR_FAULT_EN
      pwr_fault = ($urandom_range(0, 199) == 0) ? 1'b1 : (pwr_fault && ($urandom_range(0, 1) == 1));
`else
      pwr_fault = 1'($urandom_range(0, 1));
`endif
      tick();
    end
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
